// File: rtl/viterbi_pkg.sv
// Shared constants and FSM state type for the K=7 Viterbi decoder traceback path.
package viterbi_pkg;

    localparam int VIT_K          = 7;
    localparam int VIT_NUM_STATES = 1 << (VIT_K - 1);
    localparam int VIT_STATE_W    = VIT_K - 1;
    localparam int VIT_TB_DEPTH   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACE  = 2'd1,
        OUTPUT = 2'd2
    } tb_state_t;

endpackage

// File: rtl/tb_lifo.sv
// DEPTH x 1 decoded-bit buffer: written at ascending index during trace, read at descending index on output.
module tb_lifo #(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_bit,
    input  logic [IDX_W-1:0] pop_idx,
    output logic             pop_bit
);

    // Contents are don't-care after reset; every slot is rewritten before it is read.
    logic [DEPTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[push_idx] <= push_bit;
        end
    end

    assign pop_bit = mem[pop_idx];

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: walks DEPTH newest-first decision vectors back from start_state, emits bits oldest first.
// Optional VITERBI_TB_STATE_OUT_EN adds the end_state port (trellis state after the final accept).
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int NUM_STATES = VIT_NUM_STATES,
    parameter int STATE_W    = VIT_STATE_W,
    parameter int DEPTH      = VIT_TB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [STATE_W-1:0]    start_state,
    input  logic [NUM_STATES-1:0] dec,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  block_done,
    output logic                  busy
`ifdef VITERBI_TB_STATE_OUT_EN
    ,
    output logic [STATE_W-1:0]    end_state
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    tb_state_t          state;
    logic [STATE_W-1:0] s;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               u;
    logic               pred_bit;
    logic [STATE_W-1:0] s_next;
    logic [IDX_W-1:0]   rd_idx;
    logic               lifo_bit;

    // Handshake: a vector moves on any cycle with dec_valid && dec_ready; dec_ready is high only in TRACE,
    // so dec_valid in any other state consumes nothing. There is no backpressure on the bit output.
    assign accept   = (state == TRACE) && dec_valid;
    assign u        = s[STATE_W-1];
    assign pred_bit = dec[s];
    assign s_next   = {s[STATE_W-2:0], pred_bit};

    // In OUTPUT, cnt holds the index currently on bit_out, so the next one to fetch sits one below.
    assign rd_idx = IDX_W'(cnt - CNT_W'(1));

    tb_lifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_lifo (
        .clk      (clk),
        .push     (accept),
        .push_idx (cnt[IDX_W-1:0]),
        .push_bit (u),
        .pop_idx  (rd_idx),
        .pop_bit  (lifo_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s          <= '0;
            cnt        <= '0;
            dec_ready  <= 1'b0;
            busy       <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            block_done <= 1'b0;
`ifdef VITERBI_TB_STATE_OUT_EN
            end_state  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= TRACE;
                        s         <= start_state;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        dec_ready <= 1'b1;
                    end
                end
                TRACE: begin
                    if (accept) begin
                        s <= s_next;
                        // The newest-pushed bit is the first one out, so it bypasses the buffer.
                        if (cnt == CNT_W'(DEPTH - 1)) begin
                            state      <= OUTPUT;
                            dec_ready  <= 1'b0;
                            cnt        <= CNT_W'(DEPTH - 1);
                            bit_out    <= u;
                            bit_valid  <= 1'b1;
                            block_done <= (DEPTH == 1);
`ifdef VITERBI_TB_STATE_OUT_EN
                            end_state  <= s_next;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                OUTPUT: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        bit_out    <= 1'b0;
                        bit_valid  <= 1'b0;
                        block_done <= 1'b0;
                    end else begin
                        bit_out    <= lifo_bit;
                        block_done <= (cnt == CNT_W'(1));
                        cnt        <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/viterbi_traceback.md
# viterbi_traceback

Traceback unit for the K=7, 64-state Viterbi decoder in the Convolutional chain. It is the reader for the path memory's 64-bit decision vectors, which arrive newest-first. Starting from the best state supplied by the ACS stage, it walks the trellis backward over one block of `DEPTH` vectors and emits the decoded bits serially in chronological order, oldest first.

## Interface
Parameters:
- `NUM_STATES`, 64, trellis states; equals the decision vector width.
- `STATE_W`, 6, state register width (log2 of `NUM_STATES`).
- `DEPTH`, 32, decision vectors per traceback block; one decoded bit per vector.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a block; sampled only in IDLE.
- `start_state` in `STATE_W`: best end state; captured with `start`.
- `dec` in `NUM_STATES`: decision vector, newest first; bit `s` is the survivor decision of state `s`.
- `dec_valid` in 1: `dec` is valid this cycle.
- `dec_ready` out 1: ready to consume a vector; drives the path memory read enable.
- `bit_out` out 1: decoded bit.
- `bit_valid` out 1: `bit_out` is valid this cycle.
- `block_done` out 1: high together with the last `bit_valid` of a block.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, TRACE, OUTPUT.
- IDLE -> TRACE on `start`. Capture `start_state` into state register `s` and clear the vector counter.
- TRACE: `dec_ready` = 1. A vector is accepted on a cycle with `dec_valid && dec_ready`. On each accept:
  - Decoded bit `u = s[STATE_W-1]`.
  - Push `u` into the LIFO bit buffer at index `cnt`.
  - `s <= {s[STATE_W-2:0], dec[s]}` (predecessor).
  - `cnt++`.
- TRACE -> OUTPUT on the accept that makes `cnt == DEPTH`.
- OUTPUT: emit the buffer from index `DEPTH-1` down to 0, one bit per cycle, with `bit_valid` = 1.
  - There is no output backpressure.
  - On the cycle that emits index 0, `block_done` = 1. The next state is IDLE.
- `start` is ignored while `busy` is high.
- `dec_valid` outside TRACE is ignored; no vector is consumed.
- Counter arithmetic is `$clog2(DEPTH)+1` bits wide, so there is no wrap at `DEPTH`.
- Reset values: every output is 0, FSM is IDLE, `s` = 0, `cnt` = 0. Buffer contents are don't-care.
- `rst` mid-block (TRACE or OUTPUT) aborts the block. The next cycle is IDLE with all outputs 0; no partial `block_done` is produced.

## Timing
- `start` at cycle 0 → TRACE and `dec_ready` = 1 from cycle 1.
- With `dec_valid` held high, vectors are accepted on cycles 1..`DEPTH`.
- `bit_valid` is high on cycles `DEPTH`+1 .. 2·`DEPTH`, registered. `block_done` is high on cycle 2·`DEPTH`. `busy` drops on cycle 2·`DEPTH`+1.
- Each cycle with `dec_valid` low in TRACE adds one cycle of latency.
- `dec[s]` is selected combinationally from the current registered `s`. This is a 64:1 mux, and it is the critical path.

## Configuration
- `VITERBI_TB_STATE_OUT_EN` defined:
  - Adds output port `end_state` [`STATE_W`], holding `s` after the final accept.
  - `end_state` is stable from OUTPUT entry until the next `start`; its reset value is 0.
  - Used for block-boundary checks against the encoder start state.
- Macro undefined: port and register are absent; all other behaviour is identical.

## Structure
- Shared package `viterbi_pkg` holds:
  - constants `VIT_K`=7, `VIT_NUM_STATES`=64, `VIT_STATE_W`=6, `VIT_TB_DEPTH`=32;
  - FSM state typedef `tb_state_t` {IDLE, TRACE, OUTPUT}.
- One sub-module: `tb_lifo`, a `DEPTH`×1 bit buffer with push-up/pop-down index.
- Predecessor logic and FSM stay in the top module.

## Test plan
- All-zero `dec`, `start_state`=0x00 → 32 bits of 0. `block_done` at cycle 64. If enabled, `end_state`=0x00.
- All-zero `dec`, `start_state`=0x3F → trace path 3F,3E,3C,38,30,20,00…; output (oldest first) is 26×0 then 6×1. `end_state`=0x00.
- All-ones `dec`, `start_state`=0x00 → trace path 00,01,03,07,0F,1F,3F…; output is 26×1 then 6×0. `end_state`=0x3F.
- Same stimulus as case 2 with `dec_valid` toggling every cycle → identical bits; `block_done` at cycle 96.
- Second `start` pulse at cycle 10 while busy → ignored; exactly one block of 32 bits is produced.
- `rst` asserted at cycle 12 in TRACE → next cycle `busy`=0, `dec_ready`=0, no `bit_valid`. A following `start` decodes a full correct block.
